// File: rtl/hilo_muldiv.sv
// ============================================================================
//  Module   : hilo_muldiv
//  Brief    : Execute-stage MULT/MULTU/DIV/DIVU unit with the HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             flushE,
    input  logic [1:0]       hilo_weW,
    input  logic [WIDTH-1:0] wdataW,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stall_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] C_LAST_STEP = 6'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             w_start_mul;
    logic             w_start_div;
    logic             w_div_wr;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_div_hi;

    assign w_start_mul = (state_q == S_IDLE) & startE & ~opE[1] & ~flushE;
    assign w_start_div = (state_q == S_IDLE) & startE &  opE[1] & ~flushE;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_div) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else if (cnt_q == C_LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_o  = w_start_div | (state_q == S_BUSY);
        w_div_wr = (state_q == S_DONE) & ~flushE;
    end

    assign done_o = w_div_wr;

    // Both operands are widened to 2*WIDTH so one multiplier serves signed and unsigned.
    assign w_ext_a = {{WIDTH{~opE[0] & aE[WIDTH-1]}}, aE};
    assign w_ext_b = {{WIDTH{~opE[0] & bE[WIDTH-1]}}, bE};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_a_neg = ~opE[0] & aE[WIDTH-1];
    assign w_b_neg = ~opE[0] & bE[WIDTH-1];
    assign w_abs_a = w_a_neg ? (~aE + 1'b1) : aE;
    assign w_abs_b = w_b_neg ? (~bE + 1'b1) : bE;

    // Restoring step: bring in the next dividend bit, keep the difference if it is non-negative.
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, dvs_q};

    assign w_quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign w_rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    assign w_div_lo  = dz_q ? {WIDTH{1'b1}} : w_quo_fix;
    assign w_div_hi  = dz_q ? raw_a_q : w_rem_fix;

    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        raw_a_d   = raw_a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        if (w_start_div) begin
            cnt_d     = 6'd0;
            quo_d     = w_abs_a;
            rem_d     = '0;
            dvs_d     = w_abs_b;
            raw_a_d   = aE;
            neg_quo_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
            dz_d      = (bE == '0);
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q + 6'd1;
            quo_d = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
            rem_d = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
    end

    // Unit results are from the younger instruction, so they override MTHI/MTLO.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_weW[1]) begin
            hi_d = wdataW;
        end
        if (hilo_weW[0]) begin
            lo_d = wdataW;
        end
        if (w_start_mul) begin
            hi_d = w_prod[2*WIDTH-1:WIDTH];
            lo_d = w_prod[WIDTH-1:0];
        end else if (w_div_wr) begin
            hi_d = w_div_hi;
            lo_d = w_div_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 6'd0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            raw_a_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            raw_a_q   <= raw_a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

`default_nettype wire
